// File: rtl/fft16_pkg.sv
// Shared widths, twiddle table, FSM encoding and index helpers for the 16-point FFT sequencer.
package fft16_pkg;

    localparam int ADDR_W = 4;
    localparam int W_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // W_k = exp(-j*2*pi*k/16) in Q1.7; +1.0 saturates to 127
    localparam logic signed [W_W-1:0] TW_RE [8] = '{
        8'sd127, 8'sd118, 8'sd91, 8'sd49, 8'sd0, -8'sd49, -8'sd91, -8'sd118
    };
    localparam logic signed [W_W-1:0] TW_IM [8] = '{
        8'sd0, -8'sd49, -8'sd91, -8'sd118, -8'sd127, -8'sd118, -8'sd91, -8'sd49
    };

    // addr_a = (j >> s) * 2^(s+1) + (j & (2^s - 1))
    function automatic logic [ADDR_W-1:0] addr_a_of(input logic [1:0] s, input logic [2:0] j);
        logic [ADDR_W-1:0] jj;
        logic [ADDR_W-1:0] mask;
        jj   = {1'b0, j};
        mask = (4'd1 << s) - 4'd1;
        return (((jj >> s) << 1) << s) + (jj & mask);
    endfunction

    function automatic logic [ADDR_W-1:0] span_of(input logic [1:0] s);
        return 4'd1 << s;
    endfunction

    function automatic logic [2:0] tw_index(input logic [1:0] s, input logic [2:0] j);
        logic [2:0] mask;
        logic [2:0] p;
        mask = 3'((4'd1 << s) - 4'd1);
        p    = j & mask;
        return p << (2'd3 - s);
    endfunction

endpackage

// File: rtl/fft16_twiddle_rom.sv
// Combinational twiddle lookup: index k selects the Q1.7 pair (w_re, w_im).
module fft16_twiddle_rom
    import fft16_pkg::*;
(
    input  logic [2:0]            k,
    output logic signed [W_W-1:0] w_re,
    output logic signed [W_W-1:0] w_im
);

    assign w_re = TW_RE[k];
    assign w_im = TW_IM[k];

endmodule

// File: rtl/fft16_twiddle_seq.sv
// Address/twiddle issue sequencer for a 16-point radix-2 DIT FFT with per-stage drain gap.
// Optional FFT16_INVERSE_EN adds an `inverse` input that conjugates the twiddles per transform.
module fft16_twiddle_seq
    import fft16_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef FFT16_INVERSE_EN
    input  logic                  inverse,
`endif
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ADDR_W-1:0]     addr_a,
    output logic [ADDR_W-1:0]     addr_b,
    output logic signed [W_W-1:0] w_re,
    output logic signed [W_W-1:0] w_im,
    output logic [1:0]            stage,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] s, s_nxt;
    logic [2:0] j, j_nxt;
    logic [3:0] d, d_nxt;
    logic       inv_mode, inv_nxt;

    logic [2:0]            k;
    logic signed [W_W-1:0] rom_re, rom_im;

    logic                  valid_nxt, last_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0]     addr_a_nxt, addr_b_nxt;
    logic signed [W_W-1:0] w_re_nxt, w_im_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            s        <= '0;
            j        <= '0;
            d        <= '0;
            inv_mode <= 1'b0;
        end else begin
            state    <= state_nxt;
            s        <= s_nxt;
            j        <= j_nxt;
            d        <= d_nxt;
            inv_mode <= inv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        j_nxt     = j;
        d_nxt     = d;
        inv_nxt   = inv_mode;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                    s_nxt     = 2'd0;
                    j_nxt     = 3'd0;
`ifdef FFT16_INVERSE_EN
                    inv_nxt   = inverse;
`endif
                end
            end
            ST_ISSUE: begin
                if (out_valid && out_ready) begin
                    if (j == 3'd7) begin
                        state_nxt = ST_DRAIN;
                        d_nxt     = 4'd0;
                    end else begin
                        j_nxt = j + 3'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (d == DRAIN_LAST) begin
                    if (s == 2'd3) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_ISSUE;
                        s_nxt     = s + 2'd1;
                        j_nxt     = 3'd0;
                    end
                end else begin
                    d_nxt = d + 4'd1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the registered fields line up with the state.
    assign k = tw_index(s_nxt, j_nxt);

    fft16_twiddle_rom u_rom (
        .k    (k),
        .w_re (rom_re),
        .w_im (rom_im)
    );

    always_comb begin
        valid_nxt  = (state_nxt == ST_ISSUE);
        busy_nxt   = (state_nxt != ST_IDLE);
        done_nxt   = (state_nxt == ST_DONE);
        last_nxt   = valid_nxt && (s_nxt == 2'd3) && (j_nxt == 3'd7);
        addr_a_nxt = addr_a_of(s_nxt, j_nxt);
        addr_b_nxt = addr_a_nxt + span_of(s_nxt);
        w_re_nxt   = rom_re;
        w_im_nxt   = inv_nxt ? -rom_im : rom_im;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            addr_a    <= '0;
            addr_b    <= '0;
            w_re      <= '0;
            w_im      <= '0;
            stage     <= '0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= valid_nxt;
            addr_a    <= addr_a_nxt;
            addr_b    <= addr_b_nxt;
            w_re      <= w_re_nxt;
            w_im      <= w_im_nxt;
            stage     <= s_nxt;
            last      <= last_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_fft16_twiddle_seq.sv
// Directed bench for fft16_twiddle_seq: sweep, stall, mid-transform reset and (optionally) inverse twiddles.
module tb_fft16_twiddle_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    logic inverse = 1'b0;

    logic              out_valid;
    logic [3:0]        addr_a, addr_b;
    logic signed [7:0] w_re, w_im;
    logic [1:0]        stage;
    logic              last, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft16_twiddle_seq #(.DRAIN_CYCLES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FFT16_INVERSE_EN
        .inverse   (inverse),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .w_re      (w_re),
        .w_im      (w_im),
        .stage     (stage),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    // Pulse start for one cycle (cycle 0); returns at the negedge of cycle 1.
    task automatic kick(input logic inv);
        @(negedge clk);
        start   = 1'b1;
        inverse = inv;
        @(negedge clk);
        start   = 1'b0;
        inverse = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, addr_a, addr_b, w_re, w_im, stage, last, busy, done} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {out_valid, addr_a, addr_b, w_re, w_im, stage, last, busy, done});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_forward();
        int acc = 0;
        int lasts = 0;
        int done_cyc = -1;
        out_ready = 1'b1;
        kick(1'b0);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            start = (cyc == 45);
            if (cyc == 1) begin
                checks++;
                if (out_valid !== 1'b1 || addr_a !== 4'd0 || addr_b !== 4'd1 || w_re !== 127 || w_im !== 0 || stage !== 2'd0) begin
                    errors++;
                    $display("FAIL first_issue: v=%b a=%0d b=%0d w=(%0d,%0d) s=%0d, want 1 0 1 (127,0) 0",
                             out_valid, addr_a, addr_b, w_re, w_im, stage);
                end
            end
            if (out_valid && out_ready) begin
                case (acc)
                    11: begin
                        checks++;
                        if (stage !== 2'd1 || addr_a !== 4'd5 || addr_b !== 4'd7 || w_re !== 0 || w_im !== -127) begin
                            errors++;
                            $display("FAIL s1_j3: s=%0d a=%0d b=%0d w=(%0d,%0d), want 1 5 7 (0,-127)",
                                     stage, addr_a, addr_b, w_re, w_im);
                        end
                    end
                    29: begin
                        checks++;
                        if (stage !== 2'd3 || addr_a !== 4'd5 || addr_b !== 4'd13 || w_re !== -49 || w_im !== -118 || last !== 1'b0) begin
                            errors++;
                            $display("FAIL s3_j5: s=%0d a=%0d b=%0d w=(%0d,%0d) last=%b, want 3 5 13 (-49,-118) 0",
                                     stage, addr_a, addr_b, w_re, w_im, last);
                        end
                    end
                    31: begin
                        checks++;
                        if (last !== 1'b1 || addr_a !== 4'd7 || addr_b !== 4'd15 || w_re !== -118 || w_im !== -49) begin
                            errors++;
                            $display("FAIL s3_j7_last: last=%b a=%0d b=%0d w=(%0d,%0d), want 1 7 15 (-118,-49)",
                                     last, addr_a, addr_b, w_re, w_im);
                        end
                    end
                    default: ;
                endcase
                if (last) lasts++;
                acc++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (cyc == 45) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_at_done: busy=%b, want 1", busy);
                end
            end
            if (cyc == 46) begin
                checks++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL start_on_done_ignored: busy=%b valid=%b, want 0 0", busy, out_valid);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done_cyc !== 45) begin
            errors++;
            $display("FAIL done_cycle: got %0d, want 45", done_cyc);
        end
        checks++;
        if (acc !== 32 || lasts !== 1) begin
            errors++;
            $display("FAIL issue_count: issues=%0d lasts=%0d, want 32 1", acc, lasts);
        end
    endtask

    task automatic test_stall();
        int acc = 0;
        int stalls = 0;
        int done_cyc = -1;
        kick(1'b0);
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (out_valid && acc == 18 && stalls < 5) begin
                out_ready = 1'b0;
                checks++;
                if (stage !== 2'd2 || addr_a !== 4'd2 || addr_b !== 4'd6 || w_re !== 0 || w_im !== -127) begin
                    errors++;
                    $display("FAIL stall_hold_%0d: s=%0d a=%0d b=%0d w=(%0d,%0d), want 2 2 6 (0,-127)",
                             stalls, stage, addr_a, addr_b, w_re, w_im);
                end
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) acc++;
            if (done && done_cyc < 0) done_cyc = cyc;
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (acc !== 32 || stalls !== 5) begin
            errors++;
            $display("FAIL stall_issue_count: issues=%0d stalls=%0d, want 32 5", acc, stalls);
        end
        checks++;
        if (done_cyc !== 50) begin
            errors++;
            $display("FAIL stall_done_cycle: got %0d, want 50", done_cyc);
        end
    endtask

    task automatic test_mid_reset();
        int done_cyc = -1;
        out_ready = 1'b1;
        kick(1'b0);
        for (int cyc = 1; cyc < 20; cyc++) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || stage !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset_state: busy=%b stage=%0d, want 1 1", busy, stage);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({out_valid, addr_a, addr_b, w_re, w_im, stage, last, busy, done} !== 31'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b, want all zero",
                     {out_valid, addr_a, addr_b, w_re, w_im, stage, last, busy, done});
        end
        kick(1'b0);
        checks++;
        if (out_valid !== 1'b1 || stage !== 2'd0 || addr_a !== 4'd0 || addr_b !== 4'd1 || w_re !== 127 || w_im !== 0) begin
            errors++;
            $display("FAIL restart_issue: v=%b s=%0d a=%0d b=%0d w=(%0d,%0d), want 1 0 0 1 (127,0)",
                     out_valid, stage, addr_a, addr_b, w_re, w_im);
        end
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            if (done) done_cyc = cyc;
            @(negedge clk);
        end
        checks++;
        if (done_cyc !== 45) begin
            errors++;
            $display("FAIL restart_done_cycle: got %0d, want 45", done_cyc);
        end
        @(negedge clk);
    endtask

`ifdef FFT16_INVERSE_EN
    task automatic test_inverse();
        for (int pass = 0; pass < 2; pass++) begin
            int acc = 0;
            out_ready = 1'b1;
            kick(pass == 0);
            for (int cyc = 1; cyc <= 50; cyc++) begin
                if (out_valid && out_ready) begin
                    if (acc == 25) begin
                        checks++;
                        if (pass == 0 && (w_re !== 118 || w_im !== 49)) begin
                            errors++;
                            $display("FAIL inv_s3_j1: w=(%0d,%0d), want (118,49)", w_re, w_im);
                        end else if (pass == 1 && (w_re !== 118 || w_im !== -49)) begin
                            errors++;
                            $display("FAIL fwd_after_inv_s3_j1: w=(%0d,%0d), want (118,-49)", w_re, w_im);
                        end
                    end
                    if (acc == 11 && pass == 0) begin
                        checks++;
                        if (w_re !== 0 || w_im !== 127) begin
                            errors++;
                            $display("FAIL inv_s1_j3: w=(%0d,%0d), want (0,127)", w_re, w_im);
                        end
                    end
                    acc++;
                end
                @(negedge clk);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_stall();
        test_mid_reset();
`ifdef FFT16_INVERSE_EN
        test_inverse();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
